// File: rtl/uart_pkg.sv
// Shared constants for the extended UART transmitter: parity modes and FSM encoding.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    s_IDLE,
    s_START,
    s_DATA,
    s_PARITY,
    s_STOP1,
    s_STOP2
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter; full is registered so the
// write-side ready never depends on a same-cycle pop.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          pop,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     next_count;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    next_count = count;
    if (do_push && !do_pop)
      next_count = count + CNT_W'(1);
    else if (!do_push && do_pop)
      next_count = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= next_count;
      full  <= (next_count == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_ext.sv
// Parametrised UART transmitter with runtime divisor, parity and stop bits,
// fed by a small FIFO so queued frames leave back-to-back.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [DIV_WIDTH-1:0]          i_Clks_Per_Bit,
  input  logic [1:0]                    i_Parity_Mode,
  input  logic                          i_Two_Stop,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  state_t               state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] clk_count;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_en;
  logic                 par_bit;
  logic                 two_stop_q;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 frame_end;
  logic                 pop;

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .push    (i_Tx_DV),
    .wr_data (i_Tx_Byte),
    .pop     (pop),
    .rd_data (fifo_data),
    .count   (o_Fifo_Count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_Tx_Ready = !fifo_full;
  assign bit_end    = (clk_count == div_q - DIV_WIDTH'(1));
  assign frame_end  = bit_end && ((state == s_STOP2) || (state == s_STOP1 && !two_stop_q));
  // A pop both starts a frame from idle and chains the next frame with no gap.
  assign pop        = !fifo_empty && ((state == s_IDLE) || frame_end);

  // Frame configuration and data are captured at pop; no reset needed.
  always_ff @(posedge i_Clock) begin
    if (pop) begin
      div_q      <= clamp_div(i_Clks_Per_Bit);
      par_en     <= (i_Parity_Mode == PAR_EVEN) || (i_Parity_Mode == PAR_ODD);
      par_bit    <= (^fifo_data) ^ (i_Parity_Mode == PAR_ODD);
      two_stop_q <= i_Two_Stop;
      shift      <= fifo_data;
    end else if (state == s_DATA && bit_end) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= s_IDLE;
      clk_count   <= '0;
      bit_idx     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= frame_end;
      if (pop) begin
        state       <= s_START;
        clk_count   <= '0;
        o_Tx_Serial <= 1'b0;
        o_Tx_Active <= 1'b1;
      end else if (frame_end) begin
        state       <= s_IDLE;
        clk_count   <= '0;
        o_Tx_Serial <= 1'b1;
        o_Tx_Active <= 1'b0;
      end else if (state != s_IDLE && bit_end) begin
        clk_count <= '0;
        case (state)
          s_START: begin
            state       <= s_DATA;
            bit_idx     <= '0;
            o_Tx_Serial <= shift[0];
          end
          s_DATA: begin
            if (bit_idx == LAST_IDX) begin
              state       <= par_en ? s_PARITY : s_STOP1;
              o_Tx_Serial <= par_en ? par_bit : 1'b1;
            end else begin
              bit_idx     <= bit_idx + IDX_W'(1);
              o_Tx_Serial <= shift[1];
            end
          end
          s_PARITY: begin
            state       <= s_STOP1;
            o_Tx_Serial <= 1'b1;
          end
          s_STOP1: begin
            state       <= s_STOP2;
            o_Tx_Serial <= 1'b1;
          end
          default: begin
            state       <= s_IDLE;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
          end
        endcase
      end else if (state != s_IDLE) begin
        clk_count <= clk_count + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed bench for uart_tx_ext: line waveforms recorded per cycle and compared
// against hand-built frame images.
module tb_uart_tx_ext;
  import uart_pkg::*;

  localparam int DATA_BITS  = 8;
  localparam int DIV_WIDTH  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int HIST       = 4096;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 dv = 1'b0;
  logic                 two_stop = 1'b0;
  logic [DIV_WIDTH-1:0] cpb = 16'd4;
  logic [1:0]           pmode = 2'b00;
  logic [7:0]           tx_byte = 8'h00;
  logic                 ready, active, serial, done;
  logic [2:0]           count;

  always #5 clk = ~clk;

  uart_tx_ext #(
    .DATA_BITS  (DATA_BITS),
    .DIV_WIDTH  (DIV_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Clks_Per_Bit (cpb),
    .i_Parity_Mode  (pmode),
    .i_Two_Stop     (two_stop),
    .i_Tx_DV        (dv),
    .i_Tx_Byte      (tx_byte),
    .o_Tx_Ready     (ready),
    .o_Fifo_Count   (count),
    .o_Tx_Active    (active),
    .o_Tx_Serial    (serial),
    .o_Tx_Done      (done)
  );

  int   cyc = 0;
  logic ser_h [0:HIST-1];
  logic act_h [0:HIST-1];
  logic dn_h  [0:HIST-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HIST) begin
      ser_h[cyc] <= serial;
      act_h[cyc] <= active;
      dn_h[cyc]  <= done;
    end
  end

  int           tests = 0;
  int           fails = 0;
  int           base = 0;
  logic [127:0] exp_ser, exp_act, exp_dn;
  logic [127:0] got_ser, got_act, got_dn;
  logic [7:0]   burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int           burst_cnt [6] = '{0, 1, 1, 2, 3, 4};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dv  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic begin_exp();
    exp_ser = '1;
    exp_act = '0;
    exp_dn  = '0;
  endtask

  // Lays one frame (start, 8 data LSB first, optional parity, stops) at cycle offset off.
  task automatic add_frame(input int off, input logic [7:0] data, input int d, input bit pe,
                           input logic pb, input int stops, output int len);
    logic [11:0] b;
    int          nb;
    b = '0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = data[i];
    nb = 9;
    if (pe) begin
      b[nb] = pb;
      nb = nb + 1;
    end
    for (int s = 0; s < stops; s++) begin
      b[nb] = 1'b1;
      nb = nb + 1;
    end
    len = 0;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < d; j++) begin
        if (off + len < 128) begin
          exp_ser[off+len] = b[k];
          exp_act[off+len] = 1'b1;
        end
        len++;
      end
    end
    if (off + len < 128) exp_dn[off+len] = 1'b1;
  endtask

  task automatic check_line(input string tag, input int n);
    logic [127:0] m;
    m = '0;
    got_ser = '0;
    got_act = '0;
    got_dn  = '0;
    for (int i = 0; i < n; i++) begin
      m[i]       = 1'b1;
      got_ser[i] = ser_h[base+i];
      got_act[i] = act_h[base+i];
      got_dn[i]  = dn_h[base+i];
    end
    chk({tag, " serial"}, got_ser, exp_ser & m);
    chk({tag, " active"}, got_act, exp_act & m);
    chk({tag, " done"},   got_dn,  exp_dn & m);
  endtask

  task automatic single_frame(input string tag, input logic [7:0] data, input logic [DIV_WIDTH-1:0] cpb_v,
                              input logic [1:0] pm, input bit ts, input int d_eff, input bit pe, input logic pb);
    int len;
    do_reset();
    base     = cyc;
    cpb      = cpb_v;
    pmode    = pm;
    two_stop = ts;
    tx_byte  = data;
    dv       = 1'b1;
    tick();
    dv = 1'b0;
    begin_exp();
    add_frame(2, data, d_eff, pe, pb, ts ? 2 : 1, len);
    repeat (len + 2) tick();
    check_line(tag, len + 3);
  endtask

  initial begin
    int len;
    int len1;

    repeat (3) tick();
    chk("rst_serial", 128'(serial), 128'(1));
    chk("rst_active", 128'(active), 128'(0));
    chk("rst_done",   128'(done),   128'(0));
    chk("rst_count",  128'(count),  128'(0));
    chk("rst_ready",  128'(ready),  128'(1));
    rst = 1'b0;

    single_frame("a5_8n1", 8'hA5, 16'd4, PAR_NONE, 1'b0, 4, 1'b0, 1'b0);
    chk("a5_hand_serial", 128'({41'h1FF0F00F0F0, 2'b11}), got_ser);
    chk("a5_hand_active", got_act, 128'({40'hFF_FFFF_FFFF, 2'b00}));
    chk("a5_hand_done",   got_dn,  128'({1'b1, 42'b0}));

    single_frame("even_03", 8'h03, 16'd3, PAR_EVEN, 1'b0, 3, 1'b1, 1'b0);
    single_frame("odd_03",  8'h03, 16'd3, PAR_ODD,  1'b0, 3, 1'b1, 1'b1);
    single_frame("odd_01",  8'h01, 16'd3, PAR_ODD,  1'b0, 3, 1'b1, 1'b0);
    single_frame("odd_01_2stop", 8'h01, 16'd3, PAR_ODD, 1'b1, 3, 1'b1, 1'b0);
    chk("two_stop_len", 128'($countones(got_act)), 128'(36));
    single_frame("pm11_none", 8'h5A, 16'd2, 2'b11, 1'b0, 2, 1'b0, 1'b0);
    single_frame("div0", 8'h81, 16'd0, PAR_NONE, 1'b0, 2, 1'b0, 1'b0);
    single_frame("div1", 8'h81, 16'd1, PAR_NONE, 1'b0, 2, 1'b0, 1'b0);

    // Six writes into a depth-4 FIFO: the sixth is dropped, five frames chain.
    do_reset();
    base     = cyc;
    cpb      = 16'd2;
    pmode    = PAR_NONE;
    two_stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("burst_ready%0d", k), 128'(ready), 128'(k < 5));
      chk($sformatf("burst_count%0d", k), 128'(count), 128'(burst_cnt[k]));
      tx_byte = burst[k];
      dv      = 1'b1;
      tick();
    end
    dv = 1'b0;
    chk("burst_drop_count", 128'(count), 128'(4));
    chk("burst_drop_ready", 128'(ready), 128'(0));
    begin_exp();
    for (int f = 0; f < 5; f++) add_frame(2 + 20 * f, burst[f], 2, 1'b0, 1'b0, 1, len);
    repeat (98) tick();
    check_line("burst", 104);
    chk("burst_done_pulses", 128'($countones(got_dn)), 128'(5));
    chk("burst_final_count", 128'(count), 128'(0));

    // Divisor changes while the first frame is on the line.
    do_reset();
    base     = cyc;
    cpb      = 16'd4;
    pmode    = PAR_NONE;
    two_stop = 1'b0;
    tx_byte  = 8'h3C;
    dv       = 1'b1;
    tick();
    tx_byte = 8'hC3;
    tick();
    dv = 1'b0;
    tick();
    cpb = 16'd8;
    begin_exp();
    add_frame(2, 8'h3C, 4, 1'b0, 1'b0, 1, len1);
    add_frame(2 + len1, 8'hC3, 8, 1'b0, 1'b0, 1, len);
    repeat (121) tick();
    check_line("div_change", 124);

    // Reset lands during data bit 3 with a second byte still queued.
    do_reset();
    base    = cyc;
    cpb     = 16'd4;
    tx_byte = 8'hFF;
    dv      = 1'b1;
    tick();
    tx_byte = 8'h00;
    tick();
    dv = 1'b0;
    repeat (17) tick();
    chk("pre_rst_count", 128'(count), 128'(1));
    rst = 1'b1;
    tick();
    chk("mid_rst_serial", 128'(serial), 128'(1));
    chk("mid_rst_active", 128'(active), 128'(0));
    chk("mid_rst_count",  128'(count),  128'(0));
    chk("mid_rst_ready",  128'(ready),  128'(1));
    chk("mid_rst_done",   128'(done),   128'(0));
    rst = 1'b0;
    repeat (50) tick();
    begin_exp();
    for (int i = 2; i <= 5; i++)  exp_ser[i] = 1'b0;
    for (int i = 2; i <= 19; i++) exp_act[i] = 1'b1;
    check_line("rst_mid", 70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ext.md
Name: uart_tx_ext

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. It adds the following over the 8N1 block:
- configurable data width
- runtime baud divisor
- runtime parity (none/even/odd) and 1 or 2 stop bits
- small input FIFO, so frames go out back-to-back with no idle gap

It sits between the host-side byte producer and the serial TX pin in the same clock domain.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
DIV_WIDTH, 16, width of runtime bit-period divisor
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_Clks_Per_Bit  in  DIV_WIDTH  bit period in clocks; 0 and 1 treated as 2
i_Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
i_Two_Stop  in  1  1 = two stop bits
i_Tx_DV  in  1  write strobe, one byte per cycle
i_Tx_Byte  in  DATA_BITS  data to send
o_Tx_Ready  out  1  FIFO not full; a write is accepted only when high
o_Fifo_Count  out  clog2(FIFO_DEPTH)+1  entries queued, excluding the frame in flight
o_Tx_Active  out  1  frame in progress
o_Tx_Serial  out  1  serial line, idle high
o_Tx_Done  out  1  one-cycle pulse per completed frame

Behaviour:
- Clock and reset: one clock, i_Clock. Reset i_Reset is synchronous and active-high.
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, FSM=IDLE, FIFO flushed.
- Reset mid-frame: the line is high on the next edge, the frame is aborted and no Done pulse is issued.
- FIFO write: the byte is written when i_Tx_DV && o_Tx_Ready. i_Tx_DV while full is silently dropped and the count is unchanged.
- o_Tx_Ready is registered: it equals (count < FIFO_DEPTH) as of the previous edge. A write and a pop in the same cycle with a full FIFO still rejects the write.
- No bypass: a write into an empty FIFO in cycle N is popped at edge N+1, and the start bit is driven from edge N+2.
- Config capture: i_Clks_Per_Bit, i_Parity_Mode and i_Two_Stop are sampled at pop. Changes mid-frame do not affect the frame in flight.
- FSM states: IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (skipped if none) -> STOP1 -> STOP2 (only if two stop bits) -> IDLE or START.
- Every bit lasts exactly the latched divisor D in clocks.
- Bit values:
  - Start bit = 0.
  - Parity bit: even = XOR of data bits; odd = its inverse.
  - Stop bits = 1.
- Frame end, last clock of the final stop bit:
  - If the FIFO is non-empty: pop and go to START on the next edge. The start bit begins immediately after the last stop clock with no idle cycle, and o_Tx_Active stays 1.
  - Otherwise: go to IDLE and drop o_Tx_Active.
- o_Tx_Done: asserted for exactly the one cycle after the final stop bit ends. Back-to-back, it coincides with the first start-bit cycle of the next frame.
- o_Tx_Active: 1 from the first start-bit cycle until the last stop-bit cycle inclusive.
- Counter widths: the divisor counter is DIV_WIDTH bits and counts 0..D-1. The bit index is clog2(DATA_BITS) bits. No wrap is possible for legal D.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD)
  - FSM state encoding (s_IDLE, s_START, s_DATA, s_PARITY, s_STOP1, s_STOP2)
- One sub-module, uart_tx_fifo: synchronous FIFO, DATA_BITS wide, FIFO_DEPTH deep, with push/pop/count/full/empty and the same synchronous reset.
- The shift/FSM logic stays in uart_tx_ext.

Test Plan:
- D=4, 8N1, write 0xA5 at cycle 0:
  - Line low from cycle 2.
  - Then bits 1,0,1,0,0,1,0,1 then stop 1, each 4 cycles (40 cycles total).
  - Done pulse at cycle 42; Active low at 42.
- D=3, even parity, one stop bit: 0x03 -> parity bit 0. Odd parity: 0x03 -> 1, 0x01 -> 0. With two stop bits, frame length is 12*3=36 cycles.
- FIFO_DEPTH=4, D=2:
  - Write on 6 consecutive cycles; writes 1-5 are accepted (first popped), write 6 is dropped while Ready=0.
  - 5 frames go out contiguously: start bit directly follows stop bit, 5 Done pulses, Active continuously high.
- Change i_Clks_Per_Bit from 4 to 8 mid-frame: current frame keeps 4-cycle bits, next queued frame uses 8.
- Assert i_Reset during DATA bit 3: Serial=1, Active=0, Count=0, Ready=1 next cycle. No Done; no further frames from old FIFO contents.
- D=0 and D=1: each bit lasts 2 cycles.
